// File: rtl/as2650_timers_pkg.sv
// rtl/as2650_timers_pkg.sv - register map, ctrl bit indices and channel read helper for as2650_timers
package as2650_timers_pkg;

  localparam int unsigned ADDR_W = 6;

  localparam logic [5:0] T0_BASE       = 6'h00;
  localparam logic [5:0] T1_BASE       = 6'h08;
  localparam logic [5:0] PRESCALE_ADDR = 6'h10;
  localparam logic [5:0] STATUS_ADDR   = 6'h11;

  localparam logic [2:0] OFF_RELOAD_LO = 3'd0;
  localparam logic [2:0] OFF_RELOAD_HI = 3'd1;
  localparam logic [2:0] OFF_CTRL      = 3'd2;
  localparam logic [2:0] OFF_COUNT_LO  = 3'd4;
  localparam logic [2:0] OFF_COUNT_HI  = 3'd5;
  localparam logic [2:0] OFF_CMP_LO    = 3'd6;
  localparam logic [2:0] OFF_CMP_HI    = 3'd7;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_AUTO  = 1;
  localparam int CTRL_IRQEN = 2;

  // Everything a channel exposes to the register read path.
  typedef struct packed {
    logic [15:0] reload;
    logic [2:0]  ctrl;
    logic [15:0] count;
    logic [7:0]  shadow;
    logic [15:0] compare;
  } chan_view_t;

  // Byte visible at a channel offset; unmapped offsets read zero.
  function automatic logic [7:0] chan_read(input chan_view_t v, input logic [2:0] off);
    logic [7:0] d;
    d = 8'h00;
    case (off)
      OFF_RELOAD_LO: d = v.reload[7:0];
      OFF_RELOAD_HI: d = v.reload[15:8];
      OFF_CTRL:      d = {5'b00000, v.ctrl};
      OFF_COUNT_LO:  d = v.count[7:0];
      OFF_COUNT_HI:  d = v.shadow;
      OFF_CMP_LO:    d = v.compare[7:0];
      OFF_CMP_HI:    d = v.compare[15:8];
      default:       d = 8'h00;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/as2650_timer_chan.sv
// rtl/as2650_timer_chan.sv - one 16-bit down-counting timer channel (PWM compare under AS2650_TIMERS_PWM_EN)
module as2650_timer_chan
  import as2650_timers_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       wr_en,
  input  logic [2:0] wr_off,
  input  logic [7:0] wr_data,
  input  logic       cnt_rd,
  output chan_view_t view,
  output logic       flag_set,
  output logic       pwm
);

  logic [15:0] reload;
  logic [15:0] count;
  logic [15:0] compare;
  logic [2:0]  ctrl;
  logic [7:0]  shadow;
  logic        en;
  logic        auto_rl;
  logic        ctrl_wr;
  logic        start;
  logic        expire;

  assign en       = ctrl[CTRL_EN];
  assign auto_rl  = ctrl[CTRL_AUTO];
  assign ctrl_wr  = wr_en && (wr_off == OFF_CTRL);
  // Only a rising EN loads the counter; rewriting ctrl with EN already set leaves count alone.
  assign start    = ctrl_wr && wr_data[CTRL_EN] && !en;
  assign expire   = tick && en && (count == 16'h0000);
  assign flag_set = expire;

  // Reload bytes; a running count only sees them at its next reload.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      reload <= 16'h0000;
    end else if (wr_en && (wr_off == OFF_RELOAD_LO)) begin
      reload[7:0] <= wr_data;
    end else if (wr_en && (wr_off == OFF_RELOAD_HI)) begin
      reload[15:8] <= wr_data;
    end
  end

  // Ctrl register; a one-shot expiry drops EN unless software writes ctrl that clock.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      ctrl <= 3'b000;
    end else if (ctrl_wr) begin
      ctrl <= wr_data[2:0];
    end else if (expire && !auto_rl) begin
      ctrl[CTRL_EN] <= 1'b0;
    end
  end

  // Counter: load on start, otherwise step on prescale ticks while enabled.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      count <= 16'h0000;
    end else if (start) begin
      count <= reload;
    end else if (tick && en) begin
      if (count != 16'h0000) begin
        count <= count - 16'h0001;
      end else if (auto_rl) begin
        count <= reload;
      end
    end
  end

  // Latch the high byte whenever the low byte is read so lo-then-hi is coherent.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      shadow <= 8'h00;
    end else if (cnt_rd) begin
      shadow <= count[15:8];
    end
  end

`ifdef AS2650_TIMERS_PWM_EN
  // Compare bytes for the PWM threshold.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      compare <= 16'h0000;
    end else if (wr_en && (wr_off == OFF_CMP_LO)) begin
      compare[7:0] <= wr_data;
    end else if (wr_en && (wr_off == OFF_CMP_HI)) begin
      compare[15:8] <= wr_data;
    end
  end

  // Registered PWM: high while running and below the compare threshold.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      pwm <= 1'b0;
    end else begin
      pwm <= en && (count < compare);
    end
  end
`else
  assign compare = 16'h0000;
  assign pwm     = 1'b0;
`endif

  assign view = '{reload: reload, ctrl: ctrl, count: count, shadow: shadow, compare: compare};

endmodule

// File: rtl/as2650_timers.sv
// rtl/as2650_timers.sv - two-channel timer block with prescaler, status and read mux; PWM via AS2650_TIMERS_PWM_EN
module as2650_timers
  import as2650_timers_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              bus_cyc,
  input  logic              bus_we,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [7:0]        bus_data_in,
  output logic [7:0]        bus_data_out,
  output logic [1:0]        irq,
  output logic [1:0]        pwm_o
);

  logic       wr_strobe;
  logic       rd_strobe;
  logic       tick;
  logic [7:0] prescale;
  logic [7:0] pre_cnt;
  logic [1:0] flag;
  logic [1:0] flag_set;
  logic [1:0] flag_clr;
  logic [1:0] pwm;
  chan_view_t view [2];

  assign wr_strobe = bus_cyc && bus_we;
  assign rd_strobe = bus_cyc && !bus_we;
  assign tick      = (pre_cnt == prescale);

  // Shared prescale counter: tick when it reaches P, then restart from zero.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      pre_cnt <= 8'h00;
    end else if (tick) begin
      pre_cnt <= 8'h00;
    end else begin
      pre_cnt <= pre_cnt + 8'h01;
    end
  end

  // Prescale register.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      prescale <= 8'h00;
    end else if (wr_strobe && (bus_addr == PRESCALE_ADDR)) begin
      prescale <= bus_data_in;
    end
  end

  assign flag_clr = (wr_strobe && (bus_addr == STATUS_ADDR)) ? bus_data_in[1:0] : 2'b00;

  // Status flags: write-1-clear, with a same-clock set taking priority.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      flag <= 2'b00;
    end else begin
      flag <= (flag & ~flag_clr) | flag_set;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_chan
    localparam logic [5:0] BASE = (i == 0) ? T0_BASE : T1_BASE;
    logic sel;
    assign sel = (bus_addr[5:3] == BASE[5:3]);

    as2650_timer_chan u_chan (
      .clk_i    (clk_i),
      .rst_n    (rst_n),
      .tick     (tick),
      .wr_en    (wr_strobe && sel),
      .wr_off   (bus_addr[2:0]),
      .wr_data  (bus_data_in),
      .cnt_rd   (rd_strobe && sel && (bus_addr[2:0] == OFF_COUNT_LO)),
      .view     (view[i]),
      .flag_set (flag_set[i]),
      .pwm      (pwm[i])
    );

    assign irq[i] = flag[i] && view[i].ctrl[CTRL_IRQEN];
  end

  assign pwm_o = pwm;

  // Combinational read mux; anything unmapped reads zero.
  always_comb begin
    bus_data_out = 8'h00;
    if (bus_addr[5:4] == 2'b00) begin
      bus_data_out = chan_read(view[bus_addr[3]], bus_addr[2:0]);
    end else if (bus_addr == PRESCALE_ADDR) begin
      bus_data_out = prescale;
    end else if (bus_addr == STATUS_ADDR) begin
      bus_data_out = {6'b000000, flag};
    end
  end

endmodule

// File: tb/tb_as2650_timers.sv
// tb/tb_as2650_timers.sv - directed scenarios plus randomized bus traffic against a behavioural model
module tb_as2650_timers;

  logic       clk_i = 1'b0;
  logic       rst_n = 1'b0;
  logic       bus_cyc = 1'b0;
  logic       bus_we = 1'b0;
  logic [5:0] bus_addr = 6'h00;
  logic [7:0] bus_data_in = 8'h00;
  logic [7:0] bus_data_out;
  logic [1:0] irq;
  logic [1:0] pwm_o;

  int total = 0;
  int bad = 0;
  logic [7:0] last_rd;

  as2650_timers dut (
    .clk_i        (clk_i),
    .rst_n        (rst_n),
    .bus_cyc      (bus_cyc),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_data_in  (bus_data_in),
    .bus_data_out (bus_data_out),
    .irq          (irq),
    .pwm_o        (pwm_o)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural model state, plain integers.
  int m_reload [2];
  int m_cnt    [2];
  int m_cmp    [2];
  int m_shadow [2];
  bit m_en     [2];
  bit m_auto   [2];
  bit m_ie     [2];
  bit m_flag   [2];
  bit m_pwm    [2];
  int m_p;
  int m_pcnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      m_reload[ch] = 0; m_cnt[ch] = 0; m_cmp[ch] = 0; m_shadow[ch] = 0;
      m_en[ch] = 0; m_auto[ch] = 0; m_ie[ch] = 0; m_flag[ch] = 0; m_pwm[ch] = 0;
    end
    m_p = 0;
    m_pcnt = 0;
  endfunction

  function automatic int model_read(input int a);
    int ch;
    int off;
    if (a < 16) begin
      ch = a / 8;
      off = a % 8;
      case (off)
        0: return m_reload[ch] % 256;
        1: return m_reload[ch] / 256;
        2: return int'(m_en[ch]) + 2 * int'(m_auto[ch]) + 4 * int'(m_ie[ch]);
        4: return m_cnt[ch] % 256;
        5: return m_shadow[ch];
`ifdef AS2650_TIMERS_PWM_EN
        6: return m_cmp[ch] % 256;
        7: return m_cmp[ch] / 256;
`endif
        default: return 0;
      endcase
    end
    if (a == 16) return m_p;
    if (a == 17) return int'(m_flag[0]) + 2 * int'(m_flag[1]);
    return 0;
  endfunction

  function automatic int model_irq();
    return int'(m_flag[0] && m_ie[0]) + 2 * int'(m_flag[1] && m_ie[1]);
  endfunction

  // One rising edge of the reference: every decision uses the state before the edge.
  function automatic void model_edge(input bit c, input bit w, input int a, input int d, input bit r);
    bit wr;
    bit tick;
    bit set_f [2];
    int clr;
    int base;
    int off;
    bit own;
    if (!r) begin
      model_reset();
      return;
    end
    wr = c && w;
    tick = (m_pcnt == m_p);
    for (int ch = 0; ch < 2; ch++) begin
      base = ch * 8;
      own = wr && (a >= base) && (a < base + 8);
      off = a - base;
      set_f[ch] = tick && m_en[ch] && (m_cnt[ch] == 0);
`ifdef AS2650_TIMERS_PWM_EN
      m_pwm[ch] = m_en[ch] && (m_cnt[ch] < m_cmp[ch]);
`endif
      if (c && !w && a == base + 4) m_shadow[ch] = m_cnt[ch] / 256;
      if (own && off == 2 && (d & 1) != 0 && !m_en[ch]) m_cnt[ch] = m_reload[ch];
      else if (tick && m_en[ch]) begin
        if (m_cnt[ch] != 0) m_cnt[ch] = m_cnt[ch] - 1;
        else if (m_auto[ch]) m_cnt[ch] = m_reload[ch];
      end
      if (own && off == 2) begin
        m_en[ch] = (d & 1) != 0;
        m_auto[ch] = (d & 2) != 0;
        m_ie[ch] = (d & 4) != 0;
      end else if (set_f[ch] && !m_auto[ch]) begin
        m_en[ch] = 0;
      end
      if (own && off == 0) m_reload[ch] = (m_reload[ch] / 256) * 256 + d;
      if (own && off == 1) m_reload[ch] = d * 256 + m_reload[ch] % 256;
`ifdef AS2650_TIMERS_PWM_EN
      if (own && off == 6) m_cmp[ch] = (m_cmp[ch] / 256) * 256 + d;
      if (own && off == 7) m_cmp[ch] = d * 256 + m_cmp[ch] % 256;
`endif
    end
    m_pcnt = tick ? 0 : (m_pcnt + 1) % 256;
    if (wr && a == 16) m_p = d;
    clr = (wr && a == 17) ? (d & 3) : 0;
    for (int ch = 0; ch < 2; ch++) begin
      m_flag[ch] = (m_flag[ch] && ((clr >> ch) & 1) == 0) || set_f[ch];
    end
  endfunction

  // One bus clock: check the combinational read before the edge, irq/pwm after it.
  task automatic cycle(input bit c, input bit w, input int a, input int d, input bit r);
    bus_cyc = c;
    bus_we = w;
    bus_addr = 6'(a);
    bus_data_in = 8'(d);
    rst_n = r;
    #1;
    last_rd = bus_data_out;
    check("rd", {24'h0, bus_data_out}, model_read(a));
    @(posedge clk_i);
    model_edge(c, w, a, d, r);
    @(negedge clk_i);
    check("irq", {30'h0, irq}, model_irq());
    check("pwm", {30'h0, pwm_o}, int'(m_pwm[0]) + 2 * int'(m_pwm[1]));
  endtask

  task automatic wr(input int a, input int d);
    cycle(1, 1, a, d, 1);
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 1);
  endtask

  task automatic rd(input int a);
    cycle(1, 0, a, 0, 1);
  endtask

  task automatic do_reset();
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
  endtask

  // Side-effect-free look at a register between edges (at most three per clock).
  task automatic peek(input int a, output logic [7:0] v);
    bus_cyc = 0;
    bus_we = 0;
    bus_addr = 6'(a);
    #1;
    v = bus_data_out;
  endtask

  initial begin
    logic [7:0] v;
    logic [31:0] rise_mask;
    logic prev;
    int highs;
    int a;
    int d;

    // Power-up reset without model checks: the DUT state is unknown before the first edge.
    repeat (2) @(posedge clk_i);
    model_reset();
    @(negedge clk_i);
    check("rst_irq", {30'h0, irq}, 0);
    check("rst_pwm", {30'h0, pwm_o}, 0);
    for (int i = 0; i < 18; i++) cycle(0, 0, i, 0, 0);

    // Auto-reload period: reload 3, ctrl 0x07, P=0.
    cycle(0, 0, 0, 0, 1);
    wr(16, 0); wr(0, 3); wr(1, 0); wr(2, 7);
    rise_mask = 0;
    prev = irq[0];
    for (int k = 1; k <= 12; k++) begin
      if (k == 6 || k == 10) wr(17, 1); else idle();
      if (irq[0] && !prev) rise_mask = rise_mask | (32'h1 << k);
      prev = irq[0];
    end
    check("t0_period", rise_mask, 32'h0000_1110);

    // One-shot on T1 with P=3, ctrl write aligned to a tick.
    do_reset();
    wr(8, 1); wr(9, 0); wr(16, 3);
    idle(); idle(); idle();
    wr(10, 1);
    for (int k = 1; k <= 8; k++) begin
      idle();
      if (k == 7) begin peek(17, v); check("t1_not_yet", {24'h0, v}, 0); end
    end
    check("t1_irq_off", {31'h0, irq[1]}, 0);
    peek(17, v); check("t1_flag", {24'h0, v}, 2);
    peek(10, v); check("t1_ctrl", {24'h0, v}, 0);
    peek(12, v); check("t1_cnt_lo", {24'h0, v}, 0);
    cycle(0, 0, 13, 0, 1);
    peek(13, v); check("t1_shadow", {24'h0, v}, 0);

    // Coherent 16-bit read across the 0x0100 -> 0x00FF step.
    do_reset();
    wr(0, 8'h00); wr(1, 8'h01); wr(2, 1);
    rd(4);
    check("coh_lo", {24'h0, last_rd}, 0);
    rd(5);
    check("coh_hi", {24'h0, last_rd}, 1);

    // Clear coinciding with expiry leaves the flag; the next clear wins.
    do_reset();
    wr(16, 0); wr(0, 3); wr(1, 0); wr(2, 7);
    idle(); idle(); idle();
    wr(17, 1);
    check("clr_race_irq", {31'h0, irq[0]}, 1);
    peek(17, v); check("clr_race_flag", {24'h0, v}, 1);
    wr(17, 1);
    check("clr_irq", {31'h0, irq[0]}, 0);
    peek(17, v); check("clr_flag", {24'h0, v}, 0);

    // PWM duty: reload 9 auto, compare 3.
    do_reset();
    wr(0, 9); wr(1, 0); wr(6, 3); wr(7, 0); wr(2, 7);
    rd(6);
`ifdef AS2650_TIMERS_PWM_EN
    check("cmp_rd", {24'h0, last_rd}, 3);
`else
    check("cmp_rd", {24'h0, last_rd}, 0);
`endif
    highs = 0;
    for (int k = 1; k <= 40; k++) begin
      idle();
      if (k > 10 && pwm_o[0]) highs++;
    end
`ifdef AS2650_TIMERS_PWM_EN
    check("pwm_duty", highs, 9);
`else
    check("pwm_duty", highs, 0);
`endif
    check("pre_rst_irq", {31'h0, irq[0]}, 1);

    // Reset while counting with a flag set.
    cycle(0, 0, 0, 0, 0);
    check("mid_rst_irq", {30'h0, irq}, 0);
    check("mid_rst_pwm", {30'h0, pwm_o}, 0);
    peek(17, v); check("mid_rst_status", {24'h0, v}, 0);
    peek(4, v); check("mid_rst_cnt", {24'h0, v}, 0);
    peek(2, v); check("mid_rst_ctrl", {24'h0, v}, 0);
    for (int i = 0; i < 64; i++) cycle(0, 0, i, 0, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) < 90) a = $urandom_range(0, 17);
      else a = $urandom_range(0, 63);
      if (a == 16) d = $urandom_range(0, 3);
      else if (a < 16 && (a % 8 == 1 || a % 8 == 7)) d = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : 0;
      else if (a < 16 && (a % 8 == 0 || a % 8 == 6)) d = $urandom_range(0, 15);
      else d = $urandom_range(0, 255);
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, d, $urandom_range(0, 599) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
